// File: rtl/beta_mem_pkg.sv
// beta_mem_pkg: shared I/O page offsets, STATUS bit positions and defaults for the Beta memory responder
package beta_mem_pkg;
  localparam logic [7:0] OFF_TXDATA      = 8'h00;
  localparam logic [7:0] OFF_STATUS      = 8'h04;
  localparam logic [7:0] OFF_TIMER_LOAD  = 8'h08;
  localparam logic [7:0] OFF_TIMER_COUNT = 8'h0C;
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_PEND      = 3;
  localparam int ST_COUNT_LSB = 8;
  localparam logic [31:0] DEFAULT_IO_BASE = 32'hFFFF_FF00;
endpackage

// File: rtl/beta_tx_fifo.sv
// beta_tx_fifo: byte circular buffer with wrap-bit pointers; push while full is accepted only alongside a pop
module beta_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head
);
  localparam int IW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [IW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = count == (IW+1)'(DEPTH);
  assign head    = empty ? 8'h00 : mem[rd_ptr[IW-1:0]];
  // storage is data only, so it carries no reset
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[IW-1:0]] <= din;
  // pointer advance; active-low asynchronous reset empties the buffer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (IW+1)'(do_push);
      rd_ptr <= rd_ptr + (IW+1)'(do_pop);
    end
endmodule

// File: rtl/beta_mem_responder.sv
// beta_mem_responder: shared word RAM for fetch/data ports plus an I/O page with TX FIFO and interval timer
module beta_mem_responder
  import beta_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] IO_BASE    = DEFAULT_IO_BASE,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstructionAddress,
  output logic [31:0] InstructionData,
  input  logic [31:0] DataAddress,
  output logic [31:0] DataRead,
  input  logic [31:0] DataWrite,
  input  logic        WriteEnable,
  input  logic        ReadEnable,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] ram [MEM_WORDS];
  logic [31:0] iaddr, off, period, count, status, io_rd;
  logic [AW-1:0] iidx, didx;
  logic [7:0] word;
  logic is_io, io_we, wr_tx, wr_st, wr_ld, pop, expire, pend, ovf;
  logic fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  assign iaddr  = {1'b0, InstructionAddress[30:0]};
  assign iidx   = iaddr[AW+1:2];
  assign didx   = DataAddress[AW+1:2];
  assign is_io  = DataAddress >= IO_BASE;
  assign off    = DataAddress - IO_BASE;
  assign word   = {off[7:2], 2'b00};
  assign io_we  = WriteEnable && is_io && off[31:8] == '0;
  assign wr_tx  = io_we && word == OFF_TXDATA;
  assign wr_st  = io_we && word == OFF_STATUS;
  assign wr_ld  = io_we && word == OFF_TIMER_LOAD;
  assign pop    = tx_valid && tx_ready;
  assign expire = period != '0 && count == 32'd1 && !wr_ld;
  assign irq    = pend;
  assign tx_valid = !fifo_empty;
  // STATUS image and I/O read mux; unmapped offsets and TXDATA read 0
  always_comb begin
    status = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = ovf;
    status[ST_PEND]  = pend;
    status[ST_COUNT_LSB +: 4] = 4'(fifo_count);
    io_rd = off[31:8] != '0          ? '0 :
            word == OFF_STATUS       ? status :
            word == OFF_TIMER_LOAD   ? period :
            word == OFF_TIMER_COUNT  ? count : '0;
  end
  assign InstructionData = ram[iidx];
  assign DataRead = !ReadEnable ? '0 : is_io ? io_rd : ram[didx];
  // RAM store; contents survive reset and I/O-page stores never reach it
  always_ff @(posedge clk)
    if (WriteEnable && !is_io) ram[didx] <= DataWrite;
  // timer, pending flag and overflow flag; expiry beats a PEND clear, a load beats expiry
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      period <= '0;
      count  <= '0;
      pend   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ld) begin
        period <= DataWrite;
        count  <= DataWrite;
      end else if (period != '0)
        count <= count <= 32'd1 ? period : count - 32'd1;
      pend <= expire ? 1'b1 : (wr_st && DataWrite[ST_PEND]) ? 1'b0 : pend;
      ovf  <= (wr_tx && fifo_full && !pop) ? 1'b1 : (wr_st && DataWrite[ST_OVF]) ? 1'b0 : ovf;
    end
  beta_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .pop   (pop),
    .din   (DataWrite[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (tx_data)
  );
endmodule

// File: tb/tb_beta_mem_responder.sv
// tb_beta_mem_responder: directed self-checking bench for the Beta memory responder
module tb_beta_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstructionAddress = '0;
  logic [31:0] InstructionData;
  logic [31:0] DataAddress = '0;
  logic [31:0] DataRead;
  logic [31:0] DataWrite = '0;
  logic        WriteEnable = 1'b0;
  logic        ReadEnable = 1'b0;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] v;
  localparam logic [31:0] A_TX = 32'hFFFF_FF00;
  localparam logic [31:0] A_ST = 32'hFFFF_FF04;
  localparam logic [31:0] A_LD = 32'hFFFF_FF08;
  localparam logic [31:0] A_CN = 32'hFFFF_FF0C;

  beta_mem_responder dut (
    .clk(clk), .rst(rst),
    .InstructionAddress(InstructionAddress), .InstructionData(InstructionData),
    .DataAddress(DataAddress), .DataRead(DataRead), .DataWrite(DataWrite),
    .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
    .irq(irq), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    DataAddress = a;
    DataWrite = d;
    WriteEnable = 1'b1;
    tick();
    WriteEnable = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    DataAddress = a;
    ReadEnable = 1'b1;
    #1;
    d = DataRead;
    ReadEnable = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;
    tick();
    rd(A_ST, v); check("rst_status", v, 32'h0000_0002);
    rd(A_LD, v); check("rst_period", v, 32'd0);
    rd(A_CN, v); check("rst_count", v, 32'd0);
    wr(32'h40, 32'hDEADBEEF);
    wr(32'hF00, 32'hCAFEF00D);
    rd(32'h40, v); check("load_40", v, 32'hDEADBEEF);
    InstructionAddress = 32'h8000_0040;
    #1 check("fetch_super", InstructionData, 32'hDEADBEEF);
    DataAddress = 32'h40;
    ReadEnable = 1'b0;
    #1 check("read_disabled", DataRead, 32'd0);
    rd(32'h1040, v); check("wrap_index", v, 32'hDEADBEEF);
    InstructionAddress = 32'h40;
    DataAddress = 32'h40;
    DataWrite = 32'h1234_5678;
    WriteEnable = 1'b1;
    #1 check("fetch_old_word", InstructionData, 32'hDEADBEEF);
    tick();
    WriteEnable = 1'b0;
    check("fetch_new_word", InstructionData, 32'h1234_5678);
    tx_ready = 1'b0;
    wr(A_TX, 32'd1);
    check("push_valid", 32'(tx_valid), 32'd1);
    for (int i = 2; i <= 9; i++) wr(A_TX, 32'(i));
    rd(A_ST, v); check("status_full_ovf", v, 32'h0000_0805);
    rd(32'hF00, v); check("io_no_ram", v, 32'hCAFEF00D);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_byte%0d", i), 32'(tx_data), 32'(i));
      tick();
    end
    check("drained_valid", 32'(tx_valid), 32'd0);
    check("drained_data", 32'(tx_data), 32'd0);
    tx_ready = 1'b0;
    wr(A_ST, 32'h4);
    rd(A_ST, v); check("ovf_cleared", v, 32'h0000_0002);
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + 32'(i));
    rd(A_ST, v); check("full_no_ovf", v, 32'h0000_0801);
    DataAddress = A_TX;
    DataWrite = 32'h55;
    WriteEnable = 1'b1;
    tx_ready = 1'b1;
    tick();
    WriteEnable = 1'b0;
    tx_ready = 1'b0;
    rd(A_ST, v); check("full_push_pop", v, 32'h0000_0801);
    check("head_after_pop", 32'(tx_data), 32'h11);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("last_byte", 32'(tx_data), 32'h55);
    tick();
    check("empty_again", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    wr(A_LD, 32'd5);
    rd(A_LD, v); check("period_5", v, 32'd5);
    rd(A_CN, v); check("count_5", v, 32'd5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("irq_low_%0d", i), 32'(irq), 32'd0);
    end
    tick();
    check("irq_rise", 32'(irq), 32'd1);
    rd(A_CN, v); check("count_reload", v, 32'd5);
    wr(A_ST, 32'h8);
    check("irq_cleared", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("irq_still_low", 32'(irq), 32'd0);
    tick();
    check("irq_rerise", 32'(irq), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    wr(A_ST, 32'h8);
    check("expiry_wins", 32'(irq), 32'd1);
    rd(A_CN, v); check("count_after_race", v, 32'd5);
    wr(A_LD, 32'd0);
    wr(A_ST, 32'h8);
    for (int i = 0; i < 10; i++) tick();
    check("timer_off_irq", 32'(irq), 32'd0);
    rd(A_CN, v); check("timer_off_count", v, 32'd0);
    wr(A_LD, 32'd3);
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'hA2);
    wr(A_TX, 32'hA3);
    tick();
    check("pre_rst_irq", 32'(irq), 32'd1);
    check("pre_rst_valid", 32'(tx_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_irq", 32'(irq), 32'd0);
    check("async_rst_data", 32'(tx_data), 32'd0);
    rst = 1'b1;
    tick();
    rd(A_CN, v); check("rst_count_zero", v, 32'd0);
    rd(32'h40, v); check("ram_kept_40", v, 32'h1234_5678);
    rd(32'hF00, v); check("ram_kept_f00", v, 32'hCAFEF00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
